// File: rtl/inst_issue_pkg.sv
// inst_issue_pkg: shared processor types and sizing for the issue stage.
package inst_issue_pkg;
    localparam int DEPTH = 8;
    localparam int PREG_NUM = 64;
    localparam int PREG_W = $clog2(PREG_NUM);
    localparam int WB_PORTS = 2;

    typedef struct packed {
        logic clk;
        logic rst;
    } global_t;

    typedef struct packed {
        logic flush;
    } local_t;

    typedef struct packed {
        logic [PREG_W-1:0] prs;
        logic              rs_use;
        logic [PREG_W-1:0] prt;
        logic              rt_use;
        logic [PREG_W-1:0] prd;
        logic              rd_write;
    } post_rename_t;

    typedef struct packed {
        logic         inst_en;
        logic [31:0]  inst;
        post_rename_t pr;
    } inst_fifo_slot_t;

    typedef struct packed {
        logic              en;
        logic [PREG_W-1:0] preg;
    } wakeup_bus_t;

    // True when any writeback port broadcasts preg this cycle.
    function automatic logic wb_hit(wakeup_bus_t [WB_PORTS-1:0] wb, logic [PREG_W-1:0] preg);
        wb_hit = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) wb_hit |= wb[i].en && wb[i].preg == preg;
    endfunction
endpackage

// File: rtl/inst_issue_if.sv
// inst_issue_if: FIFO-head, writeback and execute handshake of the issue stage.
interface inst_issue_if;
    import inst_issue_pkg::*;
    inst_fifo_slot_t            fifo_top;
    logic                       empty;
    logic                       re;
    wakeup_bus_t [WB_PORTS-1:0] wb;
    logic                       ex_ready;
    logic                       issue_valid;
    inst_fifo_slot_t            issue_slot;

    modport master (output fifo_top, empty, wb, ex_ready, input re, issue_valid, issue_slot);
    modport slave (input fifo_top, empty, wb, ex_ready, output re, issue_valid, issue_slot);
endinterface

// File: rtl/inst_issue_busy_table.sv
// inst_issue_busy_table: per-preg busy bits with writeback wakeup and same-cycle bypass lookup.
module inst_issue_busy_table
    import inst_issue_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       set,
    input  logic [PREG_W-1:0]          set_preg,
    input  wakeup_bus_t [WB_PORTS-1:0] wb,
    input  logic [PREG_W-1:0]          rs,
    input  logic [PREG_W-1:0]          rt,
    output logic                       rs_busy,
    output logic                       rt_busy
);
    logic [PREG_NUM-1:0] busy;
    logic [PREG_NUM-1:0] clr;

    always_comb begin
        clr = '0;
        for (int i = 0; i < WB_PORTS; i++) if (wb[i].en) clr[wb[i].preg] = 1'b1;
    end

    // Set is applied after clear so a new producer wins over a stale wakeup.
    always_ff @(posedge clk) begin
        if (rst || flush) busy <= '0;
        else busy <= (busy & ~clr) | (PREG_NUM'(set) << set_preg);
    end

    assign rs_busy = busy[rs] && !wb_hit(wb, rs);
    assign rt_busy = busy[rt] && !wb_hit(wb, rt);
endmodule

// File: rtl/inst_issue.sv
// inst_issue: in-order issue from the FIFO head into a one-entry output register.
module inst_issue
    import inst_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  local_t       cntl,
    inst_issue_if.slave  bus,
    output logic [31:0]  stall_cnt
);
    inst_fifo_slot_t top;
    logic            adv;
    logic            rs_busy;
    logic            rt_busy;
    logic            bt_set;
    logic            stall_inc;
    logic [31:0]     stall_q;

    assign top = bus.fifo_top;
    assign adv = !bus.issue_valid || bus.ex_ready;
    // Bubbles bypass the operand check; they are popped but never issued.
    assign bus.re = !bus.empty && adv && !cntl.flush && !rst &&
                    (!top.inst_en || (!(top.pr.rs_use && rs_busy) && !(top.pr.rt_use && rt_busy)));
    assign bt_set = bus.re && top.inst_en && top.pr.rd_write && top.pr.prd != '0;

    inst_issue_busy_table u_bt (
        .clk      (clk),
        .rst      (rst),
        .flush    (cntl.flush),
        .set      (bt_set),
        .set_preg (top.pr.prd),
        .wb       (bus.wb),
        .rs       (top.pr.prs),
        .rt       (top.pr.prt),
        .rs_busy  (rs_busy),
        .rt_busy  (rt_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.issue_valid <= 1'b0;
            bus.issue_slot  <= '0;
        end else if (cntl.flush) begin
            bus.issue_valid <= 1'b0;
        end else if (bus.re) begin
            bus.issue_valid <= top.inst_en;
            bus.issue_slot  <= top;
        end else if (bus.ex_ready) begin
            bus.issue_valid <= 1'b0;
        end
    end

    assign stall_inc = !bus.empty && !bus.re && !cntl.flush && !(&stall_q);

    always_ff @(posedge clk) stall_q <= rst ? '0 : stall_q + 32'(stall_inc);

    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_inst_issue.sv
// tb_inst_issue: randomized and directed scoreboard bench for inst_issue.
module tb_inst_issue;
    import inst_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    local_t      cntl;
    logic [31:0] stall_cnt;

    inst_issue_if bus();

    inst_issue dut (
        .clk       (clk),
        .rst       (rst),
        .cntl      (cntl),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int                         checks = 0;
    int                         passed = 0;
    inst_fifo_slot_t            fq[$];
    inst_fifo_slot_t            exp_q[$];
    logic [PREG_NUM-1:0]        mbusy;
    logic [31:0]                scnt;
    logic                       ex_ready_v;
    logic                       flush_v;
    logic                       exp_re;
    wakeup_bus_t [WB_PORTS-1:0] wb_v;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic inst_fifo_slot_t mk(logic en, int prd, int prs, logic rsu, int prt, logic rtu, logic rdw = 1'b1);
        inst_fifo_slot_t s;
        s = '0;
        s.inst_en = en;
        s.inst = $urandom;
        s.pr.prd = PREG_W'(prd);
        s.pr.prs = PREG_W'(prs);
        s.pr.rs_use = rsu;
        s.pr.prt = PREG_W'(prt);
        s.pr.rt_use = rtu;
        s.pr.rd_write = rdw;
        return s;
    endfunction

    // An operand is available if unused, not awaiting a producer, or woken this very cycle.
    function automatic logic avail(logic used, logic [PREG_W-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) if (wb_v[i].en && wb_v[i].preg == p) hit = 1'b1;
        return !used || !mbusy[p] || hit;
    endfunction

    task automatic step();
        inst_fifo_slot_t s;
        @(negedge clk);
        bus.empty = fq.size() == 0;
        bus.fifo_top = fq.size() != 0 ? fq[0] : '0;
        bus.ex_ready = ex_ready_v;
        bus.wb = wb_v;
        cntl.flush = flush_v;
        #1;
        exp_re = fq.size() != 0 && (exp_q.size() == 0 || ex_ready_v) && !flush_v &&
                 (!fq[0].inst_en || (avail(fq[0].pr.rs_use, fq[0].pr.prs) && avail(fq[0].pr.rt_use, fq[0].pr.prt)));
        chk("re", bus.re, exp_re);
        chk("stall_cnt", stall_cnt, scnt);
        chk("busy", dut.u_bt.busy, mbusy);
        @(posedge clk);
        if (flush_v) begin
            mbusy = '0;
            exp_q.delete();
            fq.delete();
        end else begin
            if (fq.size() != 0 && !exp_re && scnt != 32'hFFFF_FFFF) scnt++;
            for (int i = 0; i < WB_PORTS; i++) if (wb_v[i].en) mbusy[wb_v[i].preg] = 1'b0;
            if (exp_re) begin
                s = fq.pop_front();
                if (s.inst_en) begin
                    exp_q.push_back(s);
                    if (s.pr.rd_write && s.pr.prd != 0) mbusy[s.pr.prd] = 1'b1;
                end
            end
        end
    endtask

    // Monitor: the issue register must mirror the oldest issued, unconsumed instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("issue_valid", bus.issue_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("issue_slot", bus.issue_slot, exp_q[0]);
                    if (bus.ex_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        mbusy = '0;
        scnt = '0;
        ex_ready_v = 1'b1;
        flush_v = 1'b0;
        wb_v = '0;
        cntl = '0;
        bus.wb = '0;
        bus.ex_ready = 1'b1;
        fq.push_back(mk(1, 3, 0, 0, 0, 0));
        bus.empty = 1'b0;
        bus.fifo_top = fq[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_re", bus.re, 0);
        chk("reset_valid", bus.issue_valid, 0);
        chk("reset_slot", bus.issue_slot, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_busy", dut.u_bt.busy, 0);
        fq.delete();
        bus.empty = 1'b1;
        bus.fifo_top = '0;
        rst = 1'b0;

        // Two independent producers back to back.
        fq.push_back(mk(1, 5, 0, 1, 0, 1));
        fq.push_back(mk(1, 6, 0, 0, 0, 0));
        repeat (3) step();
        wb_v[0] = '{1'b1, PREG_W'(5)};
        wb_v[1] = '{1'b1, PREG_W'(6)};
        step();
        wb_v = '0;

        // Dependent consumer waits for the writeback of preg 7.
        fq.push_back(mk(1, 7, 0, 0, 0, 0));
        fq.push_back(mk(1, 8, 7, 1, 0, 0));
        repeat (4) step();
        wb_v[0] = '{1'b1, PREG_W'(7)};
        step();
        wb_v = '0;
        step();

        // Execute back-pressure holds the issue register.
        fq.push_back(mk(1, 10, 0, 0, 0, 0));
        fq.push_back(mk(1, 11, 0, 0, 0, 0));
        ex_ready_v = 1'b0;
        repeat (4) step();
        ex_ready_v = 1'b1;
        repeat (4) step();

        // Bubble is popped but not issued and leaves the busy table alone.
        fq.push_back(mk(0, 13, 0, 0, 0, 0));
        repeat (2) step();

        // Flush with an instruction held and preg 9 busy.
        fq.push_back(mk(1, 9, 0, 0, 0, 0));
        step();
        fq.push_back(mk(1, 14, 0, 0, 0, 0));
        ex_ready_v = 1'b0;
        step();
        flush_v = 1'b1;
        step();
        flush_v = 1'b0;
        ex_ready_v = 1'b1;
        repeat (2) step();

        // Issue-set of preg 12 and a wakeup of preg 12 in the same cycle.
        fq.push_back(mk(1, 12, 0, 0, 0, 0));
        wb_v[1] = '{1'b1, PREG_W'(12)};
        step();
        wb_v = '0;
        repeat (2) step();

        // Randomized traffic with a small preg range to force dependences.
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < DEPTH && $urandom_range(0, 1) == 1)
                fq.push_back(mk($urandom_range(0, 9) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                                $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                                $urandom_range(0, 3) != 0));
            for (int i = 0; i < WB_PORTS; i++)
                wb_v[i] = '{$urandom_range(0, 2) == 0, PREG_W'($urandom_range(0, 15))};
            flush_v = $urandom_range(0, 63) == 0;
            ex_ready_v = !flush_v && $urandom_range(0, 3) != 0;
            step();
        end
        wb_v = '0;
        flush_v = 1'b1;
        ex_ready_v = 1'b0;
        step();
        flush_v = 1'b0;
        ex_ready_v = 1'b1;

        // Stall counter saturation: preload during an idle edge, then stall on busy preg 12.
        fq.push_back(mk(1, 12, 0, 0, 0, 0));
        repeat (2) step();
        #2 force dut.stall_q = 32'hFFFF_FFFD;
        scnt = 32'hFFFF_FFFD;
        step();
        #2 release dut.stall_q;
        fq.push_back(mk(1, 15, 12, 1, 0, 0));
        repeat (5) step();
        wb_v[0] = '{1'b1, PREG_W'(12)};
        step();
        wb_v = '0;
        repeat (2) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/inst_issue.md
Name: inst_issue

Overview:
- In-order issue stage directly downstream of the instruction FIFO.
- Each cycle it examines the FIFO top slot and checks the renamed source physical registers against an internal busy table, which is woken by writeback broadcasts.
- It pops and issues the slot into a one-entry output register when operands are ready and the execute stage can accept.
- It also keeps a saturating issue-stall performance counter.

Parameters:
- Depth, 8, depth of the upstream FIFO; sizes nothing internally but is passed for package consistency.
- PREG_NUM, 64, number of physical registers; busy table size; preg index width is $clog2(PREG_NUM).
- WB_PORTS, 2, number of writeback wakeup broadcast ports.

Ports:
- System  input  Global  carries Clk (sole clock, rising edge) and Rst (synchronous, active-high).
- Cntl  input  Local  Cntl.Flush is a synchronous pipeline flush.
- FIFO_Top  input  Inst_FIFO_Slot  head slot of the instruction FIFO.
- Empty  input  1  FIFO empty.
- Re  output  1  FIFO pop, combinational.
- WB_En  input  WB_PORTS  writeback valid per port.
- WB_Preg  input  WB_PORTS x $clog2(PREG_NUM)  writeback destination preg per port.
- Ex_Ready  input  1  execute stage accepts Issue_Slot this cycle.
- Issue_Valid  output  1  Issue_Slot holds a valid instruction.
- Issue_Slot  output  Inst_FIFO_Slot  registered issued instruction.
- Stall_Cnt  output  32  cycles in which the FIFO was non-empty but nothing was popped.

Behaviour:
- Reset (Rst=1 at a clock edge):
  - Issue_Valid=0, Issue_Slot=0, Stall_Cnt=0, all busy bits=0.
  - Re is 0 during any cycle with Rst=1.
- adv = !Issue_Valid | Ex_Ready. The output register may load only when adv=1.
- Operand readiness:
  - src_rdy(x) = !use_x | busy[preg_x]==0 | any WB_En[i] & WB_Preg[i]==preg_x (same-cycle wakeup bypass).
  - Applies to both Post_Rename sources (Prs/Rs_Use, Prt/Rt_Use).
  - Preg 0 is never busy.
- Pop condition: Re = !Empty & adv & !Cntl.Flush & !Rst & (!FIFO_Top.Inst_En | (src_rdy(rs) & src_rdy(rt))).
- Bubble handling: a slot with Inst_En=0 is popped without operand checks and is not issued.
- Output register update at the clock edge:
  - If Re: Issue_Slot<=FIFO_Top and Issue_Valid<=FIFO_Top.Inst_En.
  - Else if Ex_Ready: Issue_Valid<=0.
  - Else: hold.
  - Issue_Slot contents are don't-care when Issue_Valid=0.
- Latency: FIFO top to Issue_Valid is 1 cycle. Throughput is 1 instruction per cycle with no dependences.
- Busy table:
  - On an issuing pop (Re & Inst_En & Rd_Write & Prd!=0), busy[Prd]<=1.
  - Each WB_En[i] clears busy[WB_Preg[i]].
  - Set and clear of the same preg in the same cycle: set wins (new producer).
  - Duplicate WB_Preg values across ports are legal.
- Back-to-back dependence: consumer B behind producer A sees busy[A.Prd]=1 on the cycle after A issues and stalls until wakeup. Wakeup in cycle N allows B to issue in cycle N, arriving at Issue_Valid in N+1.
- Flush (Cntl.Flush=1):
  - Re=0.
  - Issue_Valid<=0 and all busy bits<=0 next edge, overriding any set or clear.
  - Stall_Cnt is not cleared.
- Stall_Cnt: increments when !Empty & !Re & !Cntl.Flush; saturates at 32'hFFFF_FFFF and never wraps.
- Ex_Ready with Issue_Valid=0 is ignored. The downstream stage must not see the same instruction twice.

Decomposition:
- Shared package (existing processor package) holds:
  - Global, Local, Inst_FIFO_Slot, Post_Rename.
  - New constants PREG_NUM, PREG_W, WB_PORTS.
  - New typedef Wakeup_Bus {En, Preg} per port.
- One sub-module: busy_table (PREG_NUM bits, issue-set port, WB_PORTS clear ports, flush clear, combinational lookup with bypass for two sources).
- Pop logic, output register and counter stay in inst_issue.

Test Plan:
- Reset, then two independent slots (Prd=5, 6; sources preg 0) with Ex_Ready=1 -> Re=1 on two consecutive cycles; Issue_Valid=1 for both, each 1 cycle later; busy[5]=busy[6]=1.
- A writes Prd=7, B reads Prs=7; WB_En[0]=1, WB_Preg[0]=7 three cycles after A issues -> B held with Re=0 for 3 cycles (Stall_Cnt=3), pops on the wakeup cycle, Issue_Valid=1 the next cycle.
- Issue_Valid=1 with Ex_Ready=0 for 4 cycles and FIFO non-empty -> Re=0, Issue_Slot stable, Stall_Cnt+=4; Ex_Ready=1 -> pop on that cycle.
- Slot with Inst_En=0 at top, Issue_Valid=0 -> Re=1; Issue_Valid stays 0; busy table unchanged.
- Flush asserted while Issue_Valid=1 and busy[9]=1 -> Re=0 that cycle; next cycle Issue_Valid=0 and busy[9]=0; Stall_Cnt keeps its value.
- Preload Stall_Cnt near 32'hFFFF_FFFE via a long stall, then stall 3 more cycles -> holds 32'hFFFF_FFFF with no wrap; simultaneous issue-set and WB-clear of preg 12 -> busy[12]=1.
